// File: rtl/spi_pkg.sv
// Shared SPI constants: frame geometry, opcodes and master FSM encoding.
// The slave interface imports the same package so both ends agree on framing.
package spi_pkg;

   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned DATA_BITS  = 8;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      M_IDLE  = 3'd0,
      M_SETUP = 3'd1,
      M_CMD   = 3'd2,
      M_WAIT  = 3'd3,
      M_READ  = 3'd4,
      M_HOLD  = 3'd5
   } m_state_e;

   // Only the read-data opcode turns the bus around to capture a response byte
   function automatic logic is_rd_data(input logic [1:0] op);
      return (op == OP_RD_DATA);
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: counts CLK_DIV clks per half period and flags the last clk of
// each half. SCLK only toggles while tog_i is set, so the same count times the
// SETUP and HOLD phases with SCLK parked low.
module spi_sclk_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic run_i,
   input  logic tog_i,
   output logic sclk_o,
   output logic tick_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] div_q, div_d;
   logic       sclk_q, sclk_d;

   // Strobes mark the clk whose closing edge ends a half period / moves SCLK
   always_comb begin
      tick_o = run_i && (div_q == DIV_LAST);
      rise_o = tick_o && tog_i && !sclk_q;
      fall_o = tick_o && tog_i && sclk_q;
   end

   // Next divider count and SCLK level; clear restarts the phase at frame start
   always_comb begin
      div_d  = div_q;
      sclk_d = sclk_q;
      if (clr_i || !run_i) begin
         div_d  = 8'd0;
         sclk_d = 1'b0;
      end else if (tick_o) begin
         div_d  = 8'd0;
         sclk_d = tog_i ? ~sclk_q : 1'b0;
      end else begin
         div_d  = div_q + 8'd1;
         sclk_d = sclk_q;
      end
   end

   // Divider and SCLK registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= 8'd0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_if.sv
// Single-lane SPI master (mode 0). Sends a 10-bit command frame MSB first and,
// for read-data commands, keeps clocking to capture an 8-bit response on MISO.
module spi_master_if
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned RD_WAIT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [FRAME_BITS-1:0] cmd_data_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_BITS-1:0]  rd_data_o,
   output logic                  rd_valid_o,
   output logic                  sclk_o,
   output logic                  ss_n_o,
   output logic                  mosi_o,
   input  logic                  miso_i
);

   localparam logic [4:0] CMD_LAST  = 5'(FRAME_BITS - 1);
   localparam logic [4:0] RD_LAST   = 5'(DATA_BITS - 1);
   localparam logic [4:0] WAIT_LAST = (RD_WAIT == 0) ? 5'd0 : 5'(RD_WAIT - 1);

   m_state_e              state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] sh_q, sh_d;     // MOSI is sh_q MSB; zeros shift in behind
   logic [1:0]            op_q, op_d;
   logic [DATA_BITS-1:0]  rx_q, rx_d;
   logic [DATA_BITS-1:0]  rd_data_q, rd_data_d;
   logic                  ss_n_q, ss_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  clr_s, run_s, tog_s, tick_s, rise_s, fall_s;

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr_s),
      .run_i  (run_s),
      .tog_i  (tog_s),
      .sclk_o (sclk_o),
      .tick_o (tick_s),
      .rise_o (rise_s),
      .fall_o (fall_s)
   );

   assign run_s = (state_q != M_IDLE);

   // Next-state and datapath decode; bit counter restarts on every state change
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      op_d       = op_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      ss_n_d     = ss_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      clr_s      = 1'b0;
      tog_s      = 1'b0;
      case (state_q)
         M_IDLE: begin
            // A start coinciding with the done pulse is dropped
            if (start_i && !done_q) begin
               state_d = M_SETUP;
               cnt_d   = 5'd0;
               sh_d    = cmd_data_i;
               op_d    = cmd_data_i[FRAME_BITS-1 -: 2];
               ss_n_d  = 1'b0;
               busy_d  = 1'b1;
               clr_s   = 1'b1;
            end else begin
               ss_n_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         M_SETUP: begin
            if (tick_s) begin
               state_d = M_CMD;
               cnt_d   = 5'd0;
            end else begin
               state_d = M_SETUP;
            end
         end
         M_CMD: begin
            tog_s = 1'b1;
            if (fall_s) begin
               sh_d = {sh_q[FRAME_BITS-2:0], 1'b0};
               if (cnt_q == CMD_LAST) begin
                  cnt_d = 5'd0;
                  if (is_rd_data(op_q)) begin
                     state_d = (RD_WAIT == 0) ? M_READ : M_WAIT;
                  end else begin
                     state_d = M_HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         M_WAIT: begin
            tog_s = 1'b1;
            if (fall_s) begin
               if (cnt_q == WAIT_LAST) begin
                  state_d = M_READ;
                  cnt_d   = 5'd0;
               end else begin
                  cnt_d   = cnt_q + 5'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         M_READ: begin
            tog_s = 1'b1;
            if (rise_s) begin
               rx_d = {rx_q[DATA_BITS-2:0], miso_i};
            end else begin
               rx_d = rx_q;
            end
            if (fall_s) begin
               if (cnt_q == RD_LAST) begin
                  state_d = M_HOLD;
                  cnt_d   = 5'd0;
               end else begin
                  cnt_d   = cnt_q + 5'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         M_HOLD: begin
            if (tick_s) begin
               state_d = M_IDLE;
               cnt_d   = 5'd0;
               ss_n_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (is_rd_data(op_q)) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = rx_q;
               end else begin
                  rd_valid_d = 1'b0;
                  rd_data_d  = rd_data_q;
               end
            end else begin
               state_d = M_HOLD;
            end
         end
         default: begin
            state_d = M_IDLE;
            cnt_d   = 5'd0;
            ss_n_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset parks the pins at idle levels at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= M_IDLE;
         cnt_q      <= 5'd0;
         sh_q       <= '0;
         op_q       <= 2'b00;
         rx_q       <= '0;
         rd_data_q  <= '0;
         ss_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         op_q       <= op_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         ss_n_q     <= ss_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign ss_n_o     = ss_n_q;
   assign mosi_o     = sh_q[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_master_if.sv
// Bench for spi_master_if: two instances (CLK_DIV=2/RD_WAIT=2 and
// CLK_DIV=1/RD_WAIT=0), a table of frames with a scoreboard queue of
// expectations, a behavioural mode-0 slave on MISO, and hand-written
// sequences for back-to-back starts and reset during the command phase.
module tb_spi_master_if;

   typedef struct {
      bit         b;        // 0: instance A, 1: instance B
      logic [9:0] cmd;
      logic [7:0] miso;     // byte the slave returns on a read-data frame
      logic [7:0] rd;       // rd_data expected at done
      int         inj;      // cycle after acceptance to pulse a second start (0: none)
      logic [9:0] inj_cmd;
      int         post;     // idle cycles watched after done
   } vec_t;

   logic       clk;
   logic       rst_n_a, rst_n_b;
   logic       start_a, start_b;
   logic [9:0] cmd_a, cmd_b;
   logic       miso_a, miso_b;
   logic       busy_a, done_a, rv_a, sclk_a, ss_n_a, mosi_a;
   logic       busy_b, done_b, rv_b, sclk_b, ss_n_b, mosi_b;
   logic [7:0] rd_a, rd_b;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t tbl[9];
   vec_t exp_q[$];

   spi_master_if #(.CLK_DIV(2), .RD_WAIT(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n_a), .start_i(start_a), .cmd_data_i(cmd_a),
      .busy_o(busy_a), .done_o(done_a), .rd_data_o(rd_a), .rd_valid_o(rv_a),
      .sclk_o(sclk_a), .ss_n_o(ss_n_a), .mosi_o(mosi_a), .miso_i(miso_a));

   spi_master_if #(.CLK_DIV(1), .RD_WAIT(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n_b), .start_i(start_b), .cmd_data_i(cmd_b),
      .busy_o(busy_b), .done_o(done_b), .rd_data_o(rd_b), .rd_valid_o(rv_b),
      .sclk_o(sclk_b), .ss_n_o(ss_n_b), .mosi_o(mosi_b), .miso_i(miso_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic sample(input bit b, output logic ss, output logic sc, output logic mo,
                         output logic bu, output logic dn, output logic rv, output logic [7:0] rd);
      ss = b ? ss_n_b : ss_n_a;
      sc = b ? sclk_b : sclk_a;
      mo = b ? mosi_b : mosi_a;
      bu = b ? busy_b : busy_a;
      dn = b ? done_b : done_a;
      rv = b ? rv_b   : rv_a;
      rd = b ? rd_b   : rd_a;
   endtask

   task automatic set_start(input bit b, input logic s, input logic [9:0] c);
      if (b) begin start_b = s; cmd_b = c; end
      else   begin start_a = s; cmd_a = c; end
   endtask

   task automatic set_miso(input bit b, input logic m);
      if (b) miso_b = m;
      else   miso_a = m;
   endtask

   task automatic set_rst(input bit b, input logic r);
      if (b) rst_n_b = r;
      else   rst_n_a = r;
   endtask

   // Caller is between clk edges; start is seen by exactly one rising edge
   task automatic pulse_start(input bit b, input logic [9:0] c);
      set_start(b, 1'b1, c);
      @(posedge clk);
      #1;
      set_start(b, 1'b0, c);
   endtask

   // Watches one frame from the cycle after acceptance: plays the slave,
   // collects MOSI on SCLK rises, counts SS_n-low clks, then scores against
   // the expectation popped from the queue. rst_rise>0 resets after that rise.
   task automatic monitor_frame(input int rst_rise);
      vec_t       v;
      int         cyc, rises, ss_cnt, last_rise, k, cd, rdw, n_bits, extra;
      logic [9:0] frame;
      logic       p_sclk, got, aborted, per_ok, rv_ok, mosi_ok, is_rd;
      logic       s_ss, s_sclk, s_mosi, s_busy, s_done, s_rv;
      logic [7:0] s_rd;
      v       = exp_q.pop_front();
      cd      = v.b ? 1 : 2;
      rdw     = v.b ? 0 : 2;
      is_rd   = (v.cmd[9:8] == 2'b11);
      n_bits  = is_rd ? (18 + rdw) : 10;
      cyc = 0; rises = 0; ss_cnt = 0; last_rise = 0; extra = 0;
      frame = 10'h000; p_sclk = 1'b0; got = 1'b0; aborted = 1'b0;
      per_ok = 1'b1; rv_ok = 1'b1; mosi_ok = 1'b1;
      s_rv = 1'b0; s_rd = 8'h00; s_busy = 1'b0;
      while (!got && !aborted && cyc < 400) begin
         @(negedge clk);
         cyc++;
         sample(v.b, s_ss, s_sclk, s_mosi, s_busy, s_done, s_rv, s_rd);
         if (cyc == 1) begin
            chk("first_busy", s_busy, 1);
            chk("first_ss_n", s_ss, 0);
            chk("first_mosi", s_mosi, v.cmd[9]);
         end
         if (v.inj != 0) set_start(v.b, (cyc == v.inj), v.inj_cmd);
         if (!s_ss) ss_cnt++;
         if (s_rv && !s_done) rv_ok = 1'b0;
         if (is_rd && rises >= 10 && !s_sclk && !s_ss && s_mosi) mosi_ok = 1'b0;
         if (s_sclk && !p_sclk) begin
            if (rises > 0 && (cyc - last_rise) != 2 * cd) per_ok = 1'b0;
            last_rise = cyc;
            if (rises < 10) frame = {frame[8:0], s_mosi};
            rises++;
            if (rst_rise != 0 && rises == rst_rise) begin
               set_rst(v.b, 1'b0);
               aborted = 1'b1;
            end
         end
         p_sclk = s_sclk;
         // Mode-0 slave: present the next response bit while SCLK is low
         if (!s_sclk) begin
            k = rises - 10 - rdw;
            set_miso(v.b, (k >= 0 && k < 8) ? v.miso[7 - k] : 1'b0);
         end
         if (s_done) got = 1'b1;
      end
      if (aborted) begin
         #1;
         sample(v.b, s_ss, s_sclk, s_mosi, s_busy, s_done, s_rv, s_rd);
         chk("rst_ss_n", s_ss, 1);
         chk("rst_sclk", s_sclk, 0);
         chk("rst_busy", s_busy, 0);
         chk("rst_mosi", s_mosi, 0);
         repeat (6) begin
            @(negedge clk);
            sample(v.b, s_ss, s_sclk, s_mosi, s_busy, s_done, s_rv, s_rd);
            if (s_done || !s_ss) extra++;
         end
         set_rst(v.b, 1'b1);
         repeat (6) begin
            @(negedge clk);
            sample(v.b, s_ss, s_sclk, s_mosi, s_busy, s_done, s_rv, s_rd);
            if (s_done || !s_ss) extra++;
         end
         chk("rst_no_done", extra, 0);
      end else begin
         chk("done_seen", got, 1);
         chk("mosi_frame", frame, v.cmd);
         chk("ss_low_clks", ss_cnt, cd * (2 + 2 * n_bits));
         chk("sclk_rises", rises, n_bits);
         chk("sclk_period", per_ok, 1);
         chk("busy_at_done", s_busy, 0);
         chk("rd_valid", s_rv, is_rd);
         chk("rd_valid_only_with_done", rv_ok, 1);
         chk("rd_data", s_rd, v.rd);
         if (is_rd) chk("mosi_zero_in_read", mosi_ok, 1);
         if (v.post > 0) begin
            for (int i = 0; i < v.post; i++) begin
               @(negedge clk);
               sample(v.b, s_ss, s_sclk, s_mosi, s_busy, s_done, s_rv, s_rd);
               if (s_done || s_rv || !s_ss || s_busy) extra++;
            end
            chk("idle_after_done", extra, 0);
         end
      end
   endtask

   initial begin
      vec_t       v;
      logic       s_ss, s_sclk, s_mosi, s_busy, s_done, s_rv;
      logic [7:0] s_rd;
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      cmd_a = 10'h000; cmd_b = 10'h000;
      miso_a = 1'b0; miso_b = 1'b0;

      //          b     cmd      miso   rd     inj cmd      post
      tbl[0] = '{1'b0, 10'h0A5, 8'h00, 8'h00, 0, 10'h000, 4};
      tbl[1] = '{1'b0, 10'h300, 8'hC3, 8'hC3, 0, 10'h000, 4};
      tbl[2] = '{1'b0, 10'h0A5, 8'h00, 8'hC3, 5, 10'h1FF, 120};
      tbl[3] = '{1'b0, 10'h2AA, 8'h00, 8'hC3, 0, 10'h000, 4};
      tbl[4] = '{1'b0, 10'h1FF, 8'hFF, 8'hC3, 0, 10'h000, 4};
      tbl[5] = '{1'b0, 10'h3A7, 8'h3C, 8'h3C, 0, 10'h000, 4};
      tbl[6] = '{1'b1, 10'h2AA, 8'h00, 8'h00, 0, 10'h000, 4};
      tbl[7] = '{1'b1, 10'h3FF, 8'h5A, 8'h5A, 0, 10'h000, 4};
      tbl[8] = '{1'b1, 10'h05A, 8'h00, 8'h5A, 0, 10'h000, 4};

      repeat (3) @(negedge clk);
      for (int b = 0; b < 2; b++) begin
         sample(b[0], s_ss, s_sclk, s_mosi, s_busy, s_done, s_rv, s_rd);
         chk("reset_ss_n", s_ss, 1);
         chk("reset_sclk", s_sclk, 0);
         chk("reset_mosi", s_mosi, 0);
         chk("reset_busy", s_busy, 0);
         chk("reset_done", s_done, 0);
         chk("reset_rd_valid", s_rv, 0);
         chk("reset_rd_data", s_rd, 0);
      end
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(tbl[i]);
         pulse_start(tbl[i].b, tbl[i].cmd);
         monitor_frame(0);
      end

      // Back-to-back: start held through the done cycle (dropped) and the
      // following clk (accepted), leaving one idle SS_n-high clk after done
      v = '{1'b0, 10'h155, 8'h00, 8'h3C, 0, 10'h000, 0};
      exp_q.push_back(v);
      pulse_start(1'b0, v.cmd);
      monitor_frame(0);
      v = '{1'b0, 10'h3E1, 8'hA5, 8'hA5, 0, 10'h000, 4};
      exp_q.push_back(v);
      set_start(1'b0, 1'b1, v.cmd);
      @(posedge clk);
      #1;
      chk("b2b_gap_ss_n", ss_n_a, 1);
      chk("b2b_gap_busy", busy_a, 0);
      @(posedge clk);
      #1;
      set_start(1'b0, 1'b0, v.cmd);
      monitor_frame(0);

      // Reset after the 4th command bit, then a clean frame from reset state
      v = '{1'b0, 10'h0C3, 8'h00, 8'h00, 0, 10'h000, 0};
      exp_q.push_back(v);
      pulse_start(1'b0, v.cmd);
      monitor_frame(4);
      v = '{1'b0, 10'h0A5, 8'h00, 8'h00, 0, 10'h000, 4};
      exp_q.push_back(v);
      pulse_start(1'b0, v.cmd);
      monitor_frame(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
